// File: rtl/rv_imm_pkg.sv
// Shared definitions for the RV32I/RV64I immediate-decode stage:
// immediate format codes and the base opcode map.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_Z  = 3'd6,
    FMT_SH = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate decoder: derives the format from the opcode and
// builds the XLEN-wide sign/zero-extended immediate.
module imm_format_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;
  logic       is_shift;
  logic       wide_shamt;
  fmt_e       f;

  assign opcode   = instr[6:0];
  assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    f          = FMT_R;
    illegal    = 1'b0;
    wide_shamt = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_OP_IMM: begin
        if (is_shift) f = FMT_SH;
        else          f = FMT_I;
        wide_shamt = (XLEN == 64);
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64)    illegal = 1'b1;
        else if (is_shift) f = FMT_SH;
        else               f = FMT_I;
      end
      OPC_STORE:            f = FMT_S;
      OPC_BRANCH:           f = FMT_B;
      OPC_LUI, OPC_AUIPC:   f = FMT_U;
      OPC_JAL:              f = FMT_J;
      OPC_SYSTEM:           f = FMT_Z;
      OPC_OP, OPC_MISC_MEM: f = FMT_R;
      OPC_OP_32:            illegal = (XLEN != 64);
      default:              illegal = 1'b1;
    endcase
  end

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  always_comb begin
    imm = '0;
    case (f)
      FMT_I:  imm = XLEN'($signed(instr[31:20]));
      FMT_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_SH: imm = wide_shamt ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      FMT_Z:  imm = XLEN'(instr[19:15]);
      default: imm = '0;
    endcase
  end

  assign fmt = f;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes at the input, then holds results
// in a main register M backed by a skid register K for full-rate handshaking.
module imm_decode_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
);

  typedef struct packed {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
  } entry_t;

  entry_t          in_entry, m_q, m_d, k_q, k_d;
  logic            m_valid_q, m_valid_d, k_valid_q, k_valid_d, ready_q;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            accept, drain;

  imm_format_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_entry = {in_instr, in_tag, dec_imm, dec_fmt, dec_illegal};
  assign accept   = in_valid & ready_q;
  assign drain    = m_valid_q & out_ready;

  // K can only fill while M is stalled; accept and a full K never coincide
  // because in_ready is low whenever K holds an entry.
  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (drain && k_valid_q) begin
      m_d       = k_q;
      k_valid_d = 1'b0;
    end else if (drain || !m_valid_q) begin
      m_valid_d = accept;
      if (accept) m_d = in_entry;
    end else if (accept) begin
      k_valid_d = 1'b1;
      k_d       = in_entry;
    end
  end

  // NOTE: the data registers are reset as well as the valid bits, because
  // they drive visible outputs that must read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
      ready_q   <= ~k_valid_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = m_valid_q;
  assign out_instr   = m_q.instr;
  assign out_tag     = m_q.tag;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule
